// File: rtl/burst_write_fsm_pkg.sv
// Shared types and sizing helpers for the burst write sequencer.
// The optional parity bit is enabled by defining BURST_WR_PARITY_EN.
package burst_wr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

`ifdef BURST_WR_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   // A one-word burst still needs a one-bit address.
   function automatic int addr_w(input int len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

endpackage

// File: rtl/burst_write_fsm_if.sv
// Upstream valid/ready, FIFO storage write port and status of the burst sequencer.
// The wr_data width grows by one bit when BURST_WR_PARITY_EN is defined.
interface burst_write_fsm_if
   import burst_wr_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int DATA_W    = 8,
   localparam int ADDR_W   = addr_w(BURST_LEN),
   localparam int WR_W     = DATA_W + PAR_W
);
   logic              start;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              full;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WR_W-1:0]   wr_data;
   logic              busy;
   logic              done;

   modport master (
      output start, in_data, in_valid, full,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      input  start, in_data, in_valid, full,
      output in_ready, wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/burst_write_fsm_addr_cnt.sv
// Write index counter for one burst: cleared on burst entry, advanced per accepted word.
// The index saturates at the last slot instead of wrapping inside a burst.
module burst_addr_cnt
   import burst_wr_pkg::*;
#(
   parameter int  BURST_LEN = 4,
   localparam int ADDR_W    = addr_w(BURST_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] cnt,
   output logic              last
);

   assign last = (cnt == ADDR_W'(BURST_LEN - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !last) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/burst_write_fsm.sv
// Write-side burst sequencer: takes BURST_LEN words from a valid/ready source into FIFO storage.
// Define BURST_WR_PARITY_EN to append an even-parity bit as the MSB of wr_data.
module burst_write_fsm
   import burst_wr_pkg::*;
#(
   parameter int  BURST_LEN = 4,
   parameter int  DATA_W    = 8,
   localparam int ADDR_W    = addr_w(BURST_LEN),
   localparam int WR_W      = DATA_W + PAR_W
) (
   input logic               clk,
   input logic               rst,
   burst_write_fsm_if.slave  bus
);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic              last;
   logic              xfer;
   logic              clr;
   logic [WR_W-1:0]   wr_word;

   // NOTE: in_ready is decoded from the state register rather than registered,
   // so a falling full flag lets the very same cycle accept a word.
   assign bus.in_ready = (state == WRITE) && !bus.full;
   assign xfer         = bus.in_valid && bus.in_ready;
   assign clr          = (state == IDLE) && bus.start;

`ifdef BURST_WR_PARITY_EN
   assign wr_word = {^bus.in_data, bus.in_data};
`else
   assign wr_word = bus.in_data;
`endif

   burst_addr_cnt #(.BURST_LEN(BURST_LEN)) u_addr_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (xfer),
      .cnt  (idx),
      .last (last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         bus.wr_en <= 1'b0;
         bus.done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= WRITE;
                  bus.busy <= 1'b1;
               end
            end
            WRITE: begin
               if (xfer) begin
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= idx;
                  bus.wr_data <= wr_word;
                  // done rises together with the final write strobe.
                  if (last) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_write_fsm.sv
// Directed bench for burst_write_fsm: per-cycle vector table plus reset, abort and one-word bursts.
// Compile with BURST_WR_PARITY_EN defined to exercise the parity bit.
module tb_burst_write_fsm;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   burst_write_fsm_if #(.BURST_LEN(4), .DATA_W(8)) bus  ();
   burst_write_fsm_if #(.BURST_LEN(1), .DATA_W(8)) bus1 ();

   burst_write_fsm #(.BURST_LEN(4), .DATA_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   burst_write_fsm #(.BURST_LEN(1), .DATA_W(8)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       valid;
      logic       full;
      logic [7:0] data;
      logic       rdy;
      logic       we;
      logic [1:0] addr;
      logic [7:0] wd;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   function void add(input logic st, input logic va, input logic fu, input logic [7:0] d,
                     input logic rd, input logic we, input logic [1:0] a, input logic [7:0] wd,
                     input logic bz, input logic dn);
      vec_t v;
      v.start = st; v.valid = va; v.full = fu; v.data = d;
      v.rdy = rd; v.we = we; v.addr = a; v.wd = wd; v.busy = bz; v.done = dn;
      vecs.push_back(v);
   endfunction

   function automatic logic [31:0] exp_wd(input logic [7:0] d);
`ifdef BURST_WR_PARITY_EN
      return {23'd0, ^d, d};
`else
      return {24'd0, d};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, " wr_en"},    32'(bus.wr_en),    32'd0);
      check({tag, " wr_addr"},  32'(bus.wr_addr),  32'd0);
      check({tag, " wr_data"},  32'(bus.wr_data),  32'd0);
      check({tag, " busy"},     32'(bus.busy),     32'd0);
      check({tag, " done"},     32'(bus.done),     32'd0);
   endtask

   initial begin
      rst = 1'b0;
      bus.start = 0; bus.in_valid = 0; bus.full = 0; bus.in_data = '0;
      bus1.start = 0; bus1.in_valid = 0; bus1.full = 0; bus1.in_data = '0;

      // Reset state.
      #2;
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // start valid full data | rdy we addr wd busy done
      // Basic burst A0..A3.
      add(1,0,0,8'h00, 0,0,0,8'h00, 1,0);
      add(0,1,0,8'hA0, 1,1,0,8'hA0, 1,0);
      add(0,1,0,8'hA1, 1,1,1,8'hA1, 1,0);
      add(0,1,0,8'hA2, 1,1,2,8'hA2, 1,0);
      add(0,1,0,8'hA3, 1,1,3,8'hA3, 1,1);
      add(0,0,0,8'h00, 0,0,0,8'h00, 0,0);
      add(0,0,0,8'h00, 0,0,0,8'h00, 0,0);
      // Backpressure: full for 3 cycles after the 2nd transfer.
      add(1,0,0,8'h00, 0,0,0,8'h00, 1,0);
      add(0,1,0,8'hB0, 1,1,0,8'hB0, 1,0);
      add(0,1,0,8'hB1, 1,1,1,8'hB1, 1,0);
      add(0,1,1,8'hEE, 0,0,0,8'h00, 1,0);
      add(0,1,1,8'hEE, 0,0,0,8'h00, 1,0);
      add(0,1,1,8'hEE, 0,0,0,8'h00, 1,0);
      add(0,1,0,8'hB2, 1,1,2,8'hB2, 1,0);
      add(0,1,0,8'hB3, 1,1,3,8'hB3, 1,1);
      add(0,0,0,8'h00, 0,0,0,8'h00, 0,0);
      // Upstream gaps, with data chosen to exercise parity.
      add(1,0,0,8'h00, 0,0,0,8'h00, 1,0);
      add(0,1,0,8'h07, 1,1,0,8'h07, 1,0);
      add(0,0,0,8'hFF, 1,0,0,8'h00, 1,0);
      add(0,1,0,8'h03, 1,1,1,8'h03, 1,0);
      add(0,0,0,8'hFF, 1,0,0,8'h00, 1,0);
      add(0,1,0,8'hC2, 1,1,2,8'hC2, 1,0);
      add(0,0,0,8'hFF, 1,0,0,8'h00, 1,0);
      add(0,1,0,8'hC3, 1,1,3,8'hC3, 1,1);
      add(0,0,0,8'h00, 0,0,0,8'h00, 0,0);
      // start re-pulsed while busy and in DONE: ignored.
      add(1,0,0,8'h00, 0,0,0,8'h00, 1,0);
      add(1,1,0,8'hD0, 1,1,0,8'hD0, 1,0);
      add(1,1,0,8'hD1, 1,1,1,8'hD1, 1,0);
      add(1,0,0,8'h00, 1,0,0,8'h00, 1,0);
      add(0,1,0,8'hD2, 1,1,2,8'hD2, 1,0);
      add(1,1,0,8'hD3, 1,1,3,8'hD3, 1,1);
      add(1,0,0,8'h00, 0,0,0,8'h00, 0,0);
      add(0,0,1,8'h00, 0,0,0,8'h00, 0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         bus.start    = vecs[i].start;
         bus.in_valid = vecs[i].valid;
         bus.full     = vecs[i].full;
         bus.in_data  = vecs[i].data;
         #1;
         check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
         @(posedge clk); #1;
         check($sformatf("v%0d wr_en", i), 32'(bus.wr_en), 32'(vecs[i].we));
         check($sformatf("v%0d busy", i),  32'(bus.busy),  32'(vecs[i].busy));
         check($sformatf("v%0d done", i),  32'(bus.done),  32'(vecs[i].done));
         if (vecs[i].we) begin
            check($sformatf("v%0d wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d wr_data", i), 32'(bus.wr_data), exp_wd(vecs[i].wd));
         end
      end
      bus.start = 0; bus.in_valid = 0; bus.full = 0;

      // Asynchronous abort after two writes, then a fresh burst.
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0; bus.in_valid = 1; bus.in_data = 8'h51;
      @(posedge clk); #1;
      bus.in_data = 8'h52;
      @(posedge clk); #1;
      check("abort pre wr_addr", 32'(bus.wr_addr), 32'd1);
      bus.in_data = 8'h53;
      #2;
      rst = 1'b0;
      #1;
      check_idle_outputs("abort async");
      @(posedge clk); #1;
      check_idle_outputs("abort held");
      rst = 1'b1;
      bus.in_valid = 0;
      @(posedge clk); #1;
      check("abort idle done", 32'(bus.done), 32'd0);
      bus.start = 1;
      @(posedge clk); #1;
      bus.start = 0;
      check("restart busy", 32'(bus.busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1; bus.in_data = 8'(8'h61 + k);
         @(posedge clk); #1;
         check($sformatf("restart%0d wr_en", k),   32'(bus.wr_en),   32'd1);
         check($sformatf("restart%0d wr_addr", k), 32'(bus.wr_addr), 32'(k));
         check($sformatf("restart%0d wr_data", k), 32'(bus.wr_data), exp_wd(8'(8'h61 + k)));
         check($sformatf("restart%0d done", k),    32'(bus.done),    32'(k == 3));
      end
      bus.in_valid = 0;
      @(posedge clk); #1;
      check("restart end busy", 32'(bus.busy), 32'd0);

      // One-word burst, first stalled by full.
      bus1.start = 1;
      @(posedge clk); #1;
      bus1.start = 0; bus1.full = 1; bus1.in_valid = 1; bus1.in_data = 8'h07;
      #1;
      check("len1 full in_ready", 32'(bus1.in_ready), 32'd0);
      @(posedge clk); #1;
      check("len1 full wr_en", 32'(bus1.wr_en), 32'd0);
      check("len1 full busy",  32'(bus1.busy),  32'd1);
      bus1.full = 0;
      #1;
      check("len1 in_ready", 32'(bus1.in_ready), 32'd1);
      @(posedge clk); #1;
      check("len1 wr_en",   32'(bus1.wr_en),   32'd1);
      check("len1 wr_addr", 32'(bus1.wr_addr), 32'd0);
      check("len1 wr_data", 32'(bus1.wr_data), exp_wd(8'h07));
      check("len1 done",    32'(bus1.done),    32'd1);
      bus1.in_valid = 0;
      #1;
      check("len1 done in_ready", 32'(bus1.in_ready), 32'd0);
      @(posedge clk); #1;
      check("len1 after done", 32'(bus1.done),  32'd0);
      check("len1 after busy", 32'(bus1.busy),  32'd0);
      check("len1 after we",   32'(bus1.wr_en), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
